// File: rtl/fb_line_fetcher.sv
// Framebuffer scan-out: fetches one scaled RGB332 row per line during
// horizontal blanking and expands it to 8-bit RGB during active video.
module fb_line_fetcher #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          SCALE_SHIFT  = 2,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_TOTAL      = 525,
    parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_b_in,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_b_o,
    output logic        busy
);

    localparam int WPR = (H_ACTIVE >> SCALE_SHIFT) / 4;
    localparam int AW  = $clog2(WPR);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t        state;
    logic [AW-1:0] k;
    logic [9:0]    loaded_row;
    logic [9:0]    cap_row;
    logic          row_valid;
    logic [31:0]   line_buf [WPR];

    logic [9:0]    ny;
    logic [9:0]    nrow;
    logic          start;
    logic [31:0]   row_base;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [9:0]    px;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [7:0]    pix;

    function automatic logic [23:0] expand(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6],
                c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    always_comb begin
        ny       = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
        nrow     = ny >> SCALE_SHIFT;
        start    = (x == 10'(H_ACTIVE)) && (ny < 10'(V_ACTIVE))
                   && ((nrow != loaded_row) || !row_valid);
        row_base = BASE_ADDR + 32'(nrow) * 32'(4 * WPR);
    end

    // Read data lags the address by one extra edge, so word k-1 lands
    // while address k is issued; DRAIN catches the final word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            row_valid  <= 1'b0;
            loaded_row <= '1;
            cap_row    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        k        <= '0;
                        mem_addr <= row_base;
                        cap_row  <= nrow;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    k <= k + 1'b1;
                    if (k == AW'(WPR - 1)) begin
                        state <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr + 32'd4;
                    end
                end
                DRAIN: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    row_valid  <= 1'b1;
                    loaded_row <= cap_row;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en  = ((state == FETCH) && (k != '0)) || (state == DRAIN);
        wr_idx = (state == DRAIN) ? AW'(WPR - 1) : k - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[wr_idx] <= mem_rdata;
        end
    end

    always_comb begin
        px      = x >> SCALE_SHIFT;
        rd_idx  = (x < 10'(H_ACTIVE)) ? AW'(px >> 2) : '0;
        rd_word = line_buf[rd_idx];
        unique case (px[1:0])
            2'd0:    pix = rd_word[7:0];
            2'd1:    pix = rd_word[15:8];
            2'd2:    pix = rd_word[23:16];
            default: pix = rd_word[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {r, g, b} <= '0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            blank_b_o <= 1'b0;
        end else begin
            hsync_o   <= hsync_in;
            vsync_o   <= vsync_in;
            blank_b_o <= blank_b_in;
            if (x >= 10'(H_ACTIVE) || y >= 10'(V_ACTIVE)) begin
                {r, g, b} <= '0;
            end else if (!en) begin
                {r, g, b} <= '0;
            end else if (!row_valid) begin
                {r, g, b} <= expand(BORDER_COLOR);
            end else begin
                {r, g, b} <= expand(pix);
            end
        end
    end

endmodule

// File: tb/tb_fb_line_fetcher.sv
// Bench for fb_line_fetcher: random framebuffer memory, line-level model of
// which source row is buffered, and per-cycle pixel/sync/fetch checks.
module tb_fb_line_fetcher;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          WPR    = 40;
    localparam int          NWORDS = 120 * WPR;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hsync_in;
    logic        vsync_in;
    logic        blank_b_in;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hsync_o;
    logic        vsync_o;
    logic        blank_b_o;
    logic        busy;

    always #5 clk = ~clk;

    fb_line_fetcher dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .blank_b_in(blank_b_in), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .r(r), .g(g), .b(b),
        .hsync_o(hsync_o), .vsync_o(vsync_o),
        .blank_b_o(blank_b_o), .busy(busy)
    );

    logic [31:0] tbmem [NWORDS];

    // synchronous-read data memory
    always @(posedge clk) begin
        if (mem_addr >= BASE && mem_addr < BASE + 32'(4 * NWORDS))
            mem_rdata <= tbmem[(mem_addr - BASE) >> 2];
        else
            mem_rdata <= 32'hDEAD_BEEF;
    end

    int checks = 0;
    int passed = 0;

    // model: which row the line buffer holds and the fetch in flight
    int   m_loaded = -1;
    bit   m_valid  = 0;
    bit   f_active = 0;
    int   f_j      = 0;
    int   f_row    = 0;
    bit   last_rst = 0;
    logic [26:0] pend_vid = '0;

    logic [26:0] obs_vid;
    logic [26:0] e_vid;
    logic        obs_busy;
    logic        e_busy;
    logic [31:0] obs_addr;
    logic [31:0] e_addr;

    function automatic logic [23:0] rgb(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6],
                c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    // Sample outputs of the previous cycle, advance the model, drive new inputs.
    task automatic step(input int nx, input int ty, input bit nen, input bit nrst);
        logic [31:0] w;
        logic [7:0]  c;
        logic [23:0] col;
        int nyy;
        @(negedge clk);
        obs_vid  = {r, g, b, hsync_o, vsync_o, blank_b_o};
        obs_busy = busy;
        obs_addr = mem_addr;
        e_vid    = pend_vid;
        if (last_rst) begin
            e_busy = 1'b0;
            e_addr = 32'h0;
        end else begin
            e_busy = f_active && f_j <= 40;
            e_addr = BASE + 32'(f_row * WPR * 4) + 32'(4 * (f_j > 39 ? 39 : f_j));
        end
        if (f_active) begin
            if (f_j == 41) begin
                m_loaded = f_row;
                m_valid  = 1;
                f_active = 0;
            end else begin
                f_j++;
            end
        end
        reset      = nrst;
        x          = 10'(nx);
        y          = 10'(ty);
        en         = nen;
        hsync_in   = !(nx >= 656 && nx < 752);
        vsync_in   = !(ty == 490 || ty == 491);
        blank_b_in = (nx < 640) && (ty < 480);
        if (nrst) begin
            pend_vid = {24'h0, 1'b1, 1'b1, 1'b0};
            f_active = 0;
            m_valid  = 0;
            m_loaded = -1;
        end else begin
            col = 24'h0;
            if (nx < 640 && ty < 480 && nen) begin
                if (!m_valid) begin
                    col = rgb(8'h00);
                end else begin
                    w   = tbmem[m_loaded * WPR + nx / 16];
                    c   = w[8 * ((nx / 4) % 4) +: 8];
                    col = rgb(c);
                end
            end
            pend_vid = {col, hsync_in, vsync_in, blank_b_in};
            nyy = (ty == 524) ? 0 : ty + 1;
            if (!f_active && nx == 640 && nyy < 480
                && (nyy / 4 != m_loaded || !m_valid)) begin
                f_active = 1;
                f_j      = 0;
                f_row    = nyy / 4;
            end
        end
        last_rst = nrst;
    endtask

    task automatic test_reset();
        step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(i, 0, 1, i < 2);
            checks++;
            if (obs_vid !== 27'h000_0006 || obs_busy !== 1'b0 || obs_addr !== 32'h0) begin
                $display("FAIL reset vid=%h busy=%b addr=%h req vid=000_0006 busy=0 addr=0",
                         obs_vid, obs_busy, obs_addr);
            end else passed++;
        end
    endtask

    task automatic run_line(input string nm, input int ty, input int xa,
                            input int xb, input bit nen, output int nbusy);
        nbusy = 0;
        for (int xi = xa; xi <= xb; xi++) begin
            step(xi, ty, nen, 0);
            nbusy += int'(obs_busy);
            checks++;
            if (obs_vid !== e_vid) begin
                $display("FAIL %s vid y=%0d x=%0d got %h req %h",
                         nm, ty, xi - 1, obs_vid, e_vid);
            end else passed++;
            checks++;
            if (obs_busy !== e_busy || (e_busy && obs_addr !== e_addr)) begin
                $display("FAIL %s fetch y=%0d x=%0d busy=%b addr=%h req busy=%b addr=%h",
                         nm, ty, xi - 1, obs_busy, obs_addr, e_busy, e_addr);
            end else passed++;
        end
    endtask

    task automatic test_first_fetch();
        int nb;
        run_line("wrap_fetch", 524, 600, 720, 1, nb);
        checks++;
        if (nb !== 41) $display("FAIL wrap_busy_cycles got %0d req 41", nb);
        else passed++;
    endtask

    task automatic test_pixels();
        int nb;
        int tot = 0;
        for (int ty = 0; ty < 4; ty++) begin
            run_line("pixels", ty, 0, 799, 1, nb);
            tot += nb;
        end
        checks++;
        if (tot !== 41) $display("FAIL row_reuse busy_cycles got %0d req 41", tot);
        else passed++;
    endtask

    task automatic test_en_off();
        int nb;
        int tot = 0;
        for (int ty = 4; ty < 8; ty++) begin
            run_line("en_off", ty, 0, 720, 0, nb);
            tot += nb;
        end
        checks++;
        if (tot !== 41) $display("FAIL en_off_fetch busy_cycles got %0d req 41", tot);
        else passed++;
        run_line("after_en_off", 8, 0, 700, 1, nb);
    endtask

    task automatic test_last_line();
        int nb;
        run_line("last_line", 479, 600, 720, 1, nb);
        checks++;
        if (nb !== 0) $display("FAIL y479_no_fetch busy_cycles got %0d req 0", nb);
        else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        int nb;
        run_line("mid_pre", 11, 630, 659, 1, nb);
        step(660, 11, 1, 1);
        step(661, 11, 1, 0);
        checks++;
        if (busy !== 1'b0 || obs_vid !== 27'h000_0006) begin
            $display("FAIL mid_reset busy=%b vid=%h req busy=0 vid=000_0006",
                     busy, obs_vid);
        end else passed++;
        run_line("mid_post", 11, 662, 799, 1, nb);
        run_line("border", 0, 0, 300, 1, nb);
    endtask

    task automatic test_random();
        int nb;
        int ty;
        run_line("rnd_seed", 524, 600, 720, 1, nb);
        for (int i = 0; i < 8; i++) begin
            ty = int'($urandom_range(0, 479));
            run_line("random", ty, 0, 799, ($urandom_range(0, 3) != 0), nb);
        end
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) tbmem[i] = $urandom;
        tbmem[0] = 32'h1C03_E0FF;
        reset = 1'b1; en = 1'b0; x = '0; y = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; blank_b_in = 1'b0;
        test_reset();
        test_first_fetch();
        test_pixels();
        test_en_off();
        test_last_line();
        test_reset_mid_fetch();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
